// File: rtl/sc2bin_mc_if.sv
// rtl/sc2bin_mc_if.sv - Control, stream and result signal bundle for sc2bin_mc
interface sc2bin_mc_if #(
    parameter int BITWIDTH = 8,
    parameter int NO_POS   = 2,
    parameter int NO_NEG   = 2,
    parameter int MAX_SHFT = 4
);
    localparam int SW = $clog2(MAX_SHFT + 1);

    logic                start;
    logic                clear;
    logic [SW-1:0]       shft_amt;
    logic                relu_en;
    logic [NO_POS-1:0]   sc_pos;
    logic [NO_NEG-1:0]   sc_neg;
    logic                busy;
    logic                done;
    logic [BITWIDTH-1:0] bin_out;
    logic                sat;
    logic                neg_flag;

    modport master (
        output start, clear, shft_amt, relu_en, sc_pos, sc_neg,
        input  busy, done, bin_out, sat, neg_flag
    );

    modport slave (
        input  start, clear, shft_amt, relu_en, sc_pos, sc_neg,
        output busy, done, bin_out, sat, neg_flag
    );
endinterface

// File: rtl/sc2bin_mc.sv
// rtl/sc2bin_mc.sv - Multi-cycle stochastic-to-binary converter with shift, ReLU and saturation
module sc2bin_mc #(
    parameter int BITWIDTH = 8,
    parameter int NO_POS   = 2,
    parameter int NO_NEG   = 2,
    parameter int MAX_SHFT = 4
) (
    input  logic         clk,
    input  logic         reset,
    sc2bin_mc_if.slave   bus
);
    localparam int SW   = $clog2(MAX_SHFT + 1);
    localparam int NMAX = (NO_POS > NO_NEG) ? NO_POS : NO_NEG;
    localparam int PW   = $clog2(NMAX + 1);
    localparam int AW   = BITWIDTH + PW + 1;
    localparam int VW   = AW + MAX_SHFT;
    localparam int CW   = BITWIDTH + 1;

    localparam logic signed [VW-1:0] UMAX = VW'((1 << BITWIDTH) - 1);
    localparam logic signed [VW-1:0] SMAX = VW'((1 << (BITWIDTH - 1)) - 1);
    localparam logic signed [VW-1:0] SMIN = VW'(-(1 << (BITWIDTH - 1)));

    typedef enum logic [1:0] {IDLE, COUNT, RESULT} state_t;

    state_t               state, state_nxt;
    logic [SW-1:0]        s_lat;
    logic                 relu_lat;
    logic signed [AW-1:0] acc;
    logic [CW-1:0]        cnt;

    logic                 accept;
    logic [SW-1:0]        s_new;
    logic [CW-1:0]        len_init;
    logic [PW-1:0]        pos_cnt, neg_cnt;
    logic signed [AW-1:0] delta;
    logic signed [VW-1:0] acc_ext, v;
    logic [BITWIDTH-1:0]  bin_nxt;
    logic                 sat_nxt, neg_nxt;

    // clear outranks start even in IDLE
    assign accept   = (state == IDLE) && bus.start && !bus.clear;
    assign s_new    = (bus.shft_amt > SW'(MAX_SHFT)) ? SW'(MAX_SHFT) : bus.shft_amt;
    assign len_init = CW'(1) << (CW'(BITWIDTH) - CW'(s_new));
    assign bus.busy = (state != IDLE);

    always_comb begin
        pos_cnt = '0;
        neg_cnt = '0;
        for (int i = 0; i < NO_POS; i++) pos_cnt = pos_cnt + PW'(bus.sc_pos[i]);
        for (int j = 0; j < NO_NEG; j++) neg_cnt = neg_cnt + PW'(bus.sc_neg[j]);
        delta = AW'(pos_cnt) - AW'(neg_cnt);
    end

    // Sign-extend before shifting so the scaled value is never truncated
    always_comb begin
        acc_ext = {{MAX_SHFT{acc[AW-1]}}, acc};
        v       = acc_ext <<< s_lat;
        neg_nxt = v[VW-1];
        sat_nxt = 1'b0;
        bin_nxt = v[BITWIDTH-1:0];
        if (relu_lat) begin
            if (v[VW-1]) begin
                bin_nxt = '0;
            end else if (v > UMAX) begin
                bin_nxt = '1;
                sat_nxt = 1'b1;
            end
        end else begin
            if (v > SMAX) begin
                bin_nxt = SMAX[BITWIDTH-1:0];
                sat_nxt = 1'b1;
            end else if (v < SMIN) begin
                bin_nxt = SMIN[BITWIDTH-1:0];
                sat_nxt = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = COUNT;
            COUNT: begin
                if (bus.clear)           state_nxt = IDLE;
                else if (cnt == CW'(1))  state_nxt = RESULT;
            end
            RESULT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_lat        <= '0;
            relu_lat     <= 1'b0;
            acc          <= '0;
            cnt          <= '0;
            bus.done     <= 1'b0;
            bus.bin_out  <= '0;
            bus.sat      <= 1'b0;
            bus.neg_flag <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        s_lat    <= s_new;
                        relu_lat <= bus.relu_en;
                        acc      <= '0;
                        cnt      <= len_init;
                    end
                end
                COUNT: begin
                    if (bus.clear) begin
                        cnt <= '0;
                    end else begin
                        acc <= acc + delta;
                        cnt <= cnt - CW'(1);
                    end
                end
                RESULT: begin
                    cnt <= '0;
                    if (!bus.clear) begin
                        bus.bin_out  <= bin_nxt;
                        bus.sat      <= sat_nxt;
                        bus.neg_flag <= neg_nxt;
                        bus.done     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sc2bin_mc.sv
// tb/tb_sc2bin_mc.sv - Self-checking bench for sc2bin_mc: vector table, corner sequences, random vs model
module tb_sc2bin_mc;
    logic clk;
    logic reset;

    sc2bin_mc_if #(.BITWIDTH(8), .NO_POS(2), .NO_NEG(2), .MAX_SHFT(4)) bus ();

    sc2bin_mc #(.BITWIDTH(8), .NO_POS(2), .NO_NEG(2), .MAX_SHFT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    typedef struct {
        int shft;
        int relu;
        int pat;
        int mid;
        int exp_bin;
        int exp_sat;
        int exp_neg;
        int exp_lat;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // pat: 0 ch0 toggles 1,0,..  1 all pos  2 all neg  3 random  4 silent
    task automatic run_conv(input int shft, input int relu, input int pat, input int mid,
                            input bit nowait, input bit watch,
                            output int g_bin, output int g_sat, output int g_neg,
                            output int g_lat, output int g_extra,
                            output int m_bin, output int m_sat, output int m_neg);
        int s, len, sum, cyc, v;
        logic [1:0] p, n;
        s = (shft > 4) ? 4 : shft;
        len = 256 >> s;
        sum = 0;
        g_lat = -1;
        g_extra = 0;
        if (!nowait) @(negedge clk);
        bus.start = 1'b1;
        bus.shft_amt = 3'(shft);
        bus.relu_en = relu[0];
        bus.sc_pos = '0;
        bus.sc_neg = '0;
        @(posedge clk);
        cyc = 0;
        while (cyc < 600) begin
            @(negedge clk);
            if (cyc > 0 && bus.done) begin
                g_lat = cyc;
                break;
            end
            bus.start = (cyc == mid);
            if (cyc == mid) begin
                bus.shft_amt = 3'd0;
                bus.relu_en = 1'b0;
            end
            case (pat)
                0: begin p = (cyc % 2 == 0) ? 2'b01 : 2'b00; n = 2'b00; end
                1: begin p = 2'b11; n = 2'b00; end
                2: begin p = 2'b00; n = 2'b11; end
                3: begin p = 2'($urandom); n = 2'($urandom); end
                default: begin p = 2'b00; n = 2'b00; end
            endcase
            bus.sc_pos = p;
            bus.sc_neg = n;
            if (cyc < len) sum += $countones(p) - $countones(n);
            @(posedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        g_bin = int'(bus.bin_out);
        g_sat = int'(bus.sat);
        g_neg = int'(bus.neg_flag);
        if (watch) begin
            repeat (3) begin
                @(negedge clk);
                if (bus.done) g_extra++;
            end
        end
        v = sum * (1 << s);
        m_neg = (v < 0) ? 1 : 0;
        m_sat = 0;
        if (relu != 0) begin
            if (v < 0) m_bin = 0;
            else if (v > 255) begin m_bin = 255; m_sat = 1; end
            else m_bin = v;
        end else begin
            if (v > 127) begin m_bin = 127; m_sat = 1; end
            else if (v < -128) begin m_bin = 128; m_sat = 1; end
            else m_bin = v & 255;
        end
    endtask

    initial begin
        int gb, gs, gn, gl, ge, mb, ms, mn, extra;
        string nm;
        checks = 0;
        failures = 0;

        tbl[0] = '{4, 1, 0, -1, 128, 0, 0, 17};
        tbl[1] = '{0, 1, 1, -1, 255, 1, 0, 257};
        tbl[2] = '{0, 1, 2, -1,   0, 0, 1, 257};
        tbl[3] = '{0, 0, 2, -1, 128, 1, 1, 257};
        tbl[4] = '{7, 1, 0,  5, 128, 0, 0, 17};
        tbl[5] = '{2, 0, 0, -1, 127, 1, 0, 65};
        tbl[6] = '{1, 0, 1, -1, 127, 1, 0, 129};
        tbl[7] = '{3, 1, 4, -1,   0, 0, 0, 33};

        reset = 1'b1;
        bus.start = 1'b0;
        bus.clear = 1'b0;
        bus.shft_amt = '0;
        bus.relu_en = 1'b0;
        bus.sc_pos = '0;
        bus.sc_neg = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_bin", int'(bus.bin_out), 0);
        check("reset_sat", int'(bus.sat), 0);
        check("reset_neg", int'(bus.neg_flag), 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_conv(tbl[i].shft, tbl[i].relu, tbl[i].pat, tbl[i].mid, 1'b0, 1'b1,
                     gb, gs, gn, gl, ge, mb, ms, mn);
            nm = $sformatf("row%0d", i);
            check({nm, "_bin"}, gb, tbl[i].exp_bin);
            check({nm, "_sat"}, gs, tbl[i].exp_sat);
            check({nm, "_neg"}, gn, tbl[i].exp_neg);
            check({nm, "_lat"}, gl, tbl[i].exp_lat);
            check({nm, "_single_done"}, ge, 0);
        end

        // back-to-back: second start issued on the done cycle
        run_conv(4, 1, 0, -1, 1'b0, 1'b0, gb, gs, gn, gl, ge, mb, ms, mn);
        check("b2b_first_lat", gl, 17);
        run_conv(4, 0, 1, -1, 1'b1, 1'b1, gb, gs, gn, gl, ge, mb, ms, mn);
        check("b2b_second_lat", gl, 17);
        check("b2b_second_bin", gb, 127);
        check("b2b_second_sat", gs, 1);

        // clear during COUNT
        @(negedge clk);
        bus.start = 1'b1;
        bus.shft_amt = 3'd4;
        bus.relu_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.sc_pos = 2'b11;
            @(posedge clk);
            @(negedge clk);
        end
        check("clear_busy_before", int'(bus.busy), 1);
        bus.clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.clear = 1'b0;
        bus.sc_pos = '0;
        check("clear_busy", int'(bus.busy), 0);
        check("clear_bin_kept", int'(bus.bin_out), 127);
        check("clear_sat_kept", int'(bus.sat), 1);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) extra++;
        end
        check("clear_no_done", extra, 0);

        // asynchronous reset during COUNT
        bus.start = 1'b1;
        bus.shft_amt = 3'd4;
        bus.relu_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) begin
            bus.sc_pos = 2'b01;
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        reset = 1'b1;
        #1;
        check("areset_busy", int'(bus.busy), 0);
        check("areset_bin", int'(bus.bin_out), 0);
        check("areset_sat", int'(bus.sat), 0);
        check("areset_neg", int'(bus.neg_flag), 0);
        check("areset_done", int'(bus.done), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) extra++;
        end
        check("areset_no_done", extra, 0);
        bus.sc_pos = '0;

        for (int r = 0; r < 20; r++) begin
            int sh, rl;
            sh = int'($urandom_range(0, 7));
            rl = int'($urandom_range(0, 1));
            run_conv(sh, rl, 3, -1, 1'b0, 1'b0, gb, gs, gn, gl, ge, mb, ms, mn);
            nm = $sformatf("rand%0d_s%0d_r%0d", r, sh, rl);
            check({nm, "_bin"}, gb, mb);
            check({nm, "_sat"}, gs, ms);
            check({nm, "_neg"}, gn, mn);
            check({nm, "_lat"}, gl, (256 >> ((sh > 4) ? 4 : sh)) + 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
